// File: rtl/dm_access_ctrl.sv
// Two-requester access controller for the 128-byte big-endian word DM: arbitrates,
// turns sub-word stores into read-modify-write and right-justifies sub-word loads.
module dm_access_ctrl #(
  parameter bit RR_EN    = 1'b1,
  parameter bit SIGN_EXT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  input  logic [6:0]  addr0,
  input  logic [6:0]  addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [6:0]  MemAddr,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemReadData
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e      state;
  logic        lat_id;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic [1:0]  lat_off;
  logic [31:0] lat_wdata;
  logic        last_id;

  logic        sel_id;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic [6:0]  sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_bad;

  // Lane 0 is the most significant byte (big-endian).
  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] m;
    m = old;
    case (sz)
      2'b00: begin
        case (off)
          2'd0:    m[31:24] = wd[7:0];
          2'd1:    m[23:16] = wd[7:0];
          2'd2:    m[15:8]  = wd[7:0];
          default: m[7:0]   = wd[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) m[15:0] = wd[15:0];
        else        m[31:16] = wd[15:0];
      end
      default: m = wd;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      2'b00:   r = SIGN_EXT ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   r = SIGN_EXT ? {{16{h[15]}}, h} : {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // On a tie the requester not served last wins; otherwise whoever is asking.
  always_comb begin
    sel_id = 1'b0;
    if (req0 && req1) sel_id = RR_EN ? ~last_id : 1'b0;
    else if (req1)    sel_id = 1'b1;
  end

  always_comb begin
    sel_we    = sel_id ? we1 : we0;
    sel_size  = sel_id ? size1 : size0;
    sel_addr  = sel_id ? addr1 : addr0;
    sel_wdata = sel_id ? wdata1 : wdata0;
    sel_bad   = (sel_size == 2'b11) ||
                ((sel_size == 2'b01) && sel_addr[0]) ||
                ((sel_size == 2'b10) && (sel_addr[1:0] != 2'b00));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      lat_id       <= 1'b0;
      lat_we       <= 1'b0;
      lat_size     <= 2'b00;
      lat_off      <= 2'b00;
      lat_wdata    <= '0;
      last_id      <= 1'b1;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
      MemAddr      <= '0;
      MemWriteData <= '0;
      MemWrite     <= 1'b0;
      MemRead      <= 1'b0;
    end else begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req0 || req1) begin
            lat_id    <= sel_id;
            lat_we    <= sel_we;
            lat_size  <= sel_size;
            lat_off   <= sel_addr[1:0];
            lat_wdata <= sel_wdata;
            MemAddr   <= {sel_addr[6:2], 2'b00};
            if (sel_bad) begin
              state <= StDone;
              ack0  <= ~sel_id;
              ack1  <= sel_id;
              err0  <= ~sel_id;
              err1  <= sel_id;
            end else if (sel_we && (sel_size == 2'b10)) begin
              state        <= StWr;
              MemWrite     <= 1'b1;
              MemWriteData <= sel_wdata;
            end else begin
              state   <= StRd;
              MemRead <= 1'b1;
            end
          end
        end
        StRd: begin
          if (lat_we) begin
            // MemWriteData doubles as the captured word register for the merge.
            state        <= StWr;
            MemWrite     <= 1'b1;
            MemWriteData <= merge_word(MemReadData, lat_wdata, lat_size, lat_off);
          end else begin
            state <= StDone;
            ack0  <= ~lat_id;
            ack1  <= lat_id;
            if (lat_id) rdata1 <= extract(MemReadData, lat_size, lat_off);
            else        rdata0 <= extract(MemReadData, lat_size, lat_off);
          end
        end
        StWr: begin
          state <= StDone;
          ack0  <= ~lat_id;
          ack1  <= lat_id;
        end
        StDone: begin
          state   <= StIdle;
          last_id <= lat_id;
        end
      endcase
    end
  end

endmodule
